// File: rtl/zap_fetch_queue_pkg.sv
// ============================================================================
// Module   : zap_fetch_queue_pkg
// Brief    : Shared entry layout and types for the fetch queue.
//            The decode side uses the same definitions to unpack entries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package zap_fetch_queue_pkg;

  // Entry field widths.
  localparam int FQ_INSTR_W = 32;
  localparam int FQ_ABORT_W = 1;
  localparam int FQ_PC_W    = 32;
  localparam int FQ_PC8_W   = 32;
  localparam int FQ_TAKEN_W = 2;

  // Entry field offsets (LSB position within the packed entry).
  localparam int FQ_INSTR_LSB = 0;
  localparam int FQ_ABORT_LSB = FQ_INSTR_LSB + FQ_INSTR_W;
  localparam int FQ_PC_LSB    = FQ_ABORT_LSB + FQ_ABORT_W;
  localparam int FQ_PC8_LSB   = FQ_PC_LSB    + FQ_PC_W;
  localparam int FQ_TAKEN_LSB = FQ_PC8_LSB   + FQ_PC8_W;

  // Total entry width; derived from the fields and never overridden.
  localparam int EW = FQ_TAKEN_LSB + FQ_TAKEN_W;

  // Branch predictor state carried alongside each instruction.
  typedef enum logic [1:0] {
    BP_SNT = 2'd0,
    BP_WNT = 2'd1,
    BP_WT  = 2'd2,
    BP_ST  = 2'd3
  } bp_state_e;

  // Packed entry; the first member is the MSB so offsets above match.
  typedef struct packed {
    logic [FQ_TAKEN_W-1:0] taken;
    logic [FQ_PC8_W-1:0]   pc_plus_8;
    logic [FQ_PC_W-1:0]    pc;
    logic                  abort;
    logic [FQ_INSTR_W-1:0] instr;
  } fq_entry_t;

  // Value presented to decode while the queue is empty.
  function automatic fq_entry_t fq_idle_entry();
    fq_entry_t e;
    e.taken     = BP_SNT;
    e.pc_plus_8 = 32'd8;
    e.pc        = 32'd0;
    e.abort     = 1'b0;
    e.instr     = 32'd0;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zap_fifo_ctrl.sv
// ============================================================================
// Module   : zap_fifo_ctrl
// Brief    : Pointer/count bookkeeping for the fetch queue, including the
//            flush/freeze/stall priority resolution and push/pop qualification.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zap_fifo_ctrl
  import zap_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear_from_writeback,
  input  logic                       i_data_stall,
  input  logic                       i_clear_from_alu,
  input  logic                       i_down_stall,
  input  logic                       i_clear_from_decode,
  input  logic                       i_push_req,
  output logic                       o_push,
  output logic                       o_pop,
  output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
  output logic [$clog2(DEPTH)-1:0]   o_wr_ptr,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_flush;
  logic w_not_full;
  logic w_has_data;

  // Resolve event priority: writeback clear beats data stall, which masks the
  // ALU clear; the decode clear is only honoured when no downstream stall.
  always_comb begin
    w_flush    = i_clear_from_writeback |
                 (~i_data_stall & (i_clear_from_alu |
                                   (~i_down_stall & i_clear_from_decode)));
    w_not_full = (r_count < CW'(DEPTH));
    w_has_data = (r_count != '0);
    o_push     = i_push_req & w_not_full & ~w_flush & ~i_data_stall;
    o_pop      = w_has_data & ~i_down_stall & ~w_flush & ~i_data_stall;
  end

  // Pointer and occupancy update; any clear empties the queue outright.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (o_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({o_push, o_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Backpressure leaves one spare slot for fetch's registered response.
  always_comb begin
    o_rd_ptr      = r_rd_ptr;
    o_wr_ptr      = r_wr_ptr;
    o_count       = r_count;
    o_empty       = ~w_has_data;
    o_almost_full = (r_count >= CW'(DEPTH - 1));
  end

endmodule

`default_nettype wire

// File: rtl/zap_fetch_queue.sv
// ============================================================================
// Module   : zap_fetch_queue
// Brief    : Instruction FIFO between fetch and decode. Lets fetch run ahead
//            by DEPTH entries, flushes on every pipeline clear and drives
//            registered-count backpressure back to fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zap_fetch_queue
  import zap_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic        i_clear_from_decode,
  input  logic [31:0] i_instruction,
  input  logic        i_valid,
  input  logic        i_instr_abort,
  input  logic [31:0] i_pc_ff,
  input  logic [31:0] i_pc_plus_8_ff,
  input  logic [1:0]  i_taken,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_pc_plus_8_ff,
  output logic [1:0]  o_taken_ff,
  output logic        o_stall_from_queue
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t      r_mem [DEPTH];
  fq_entry_t      w_wr_entry;
  fq_entry_t      w_head;
  logic           w_down_stall;
  logic           w_push;
  logic           w_pop;
  logic [PW-1:0]  w_rd_ptr;
  logic [PW-1:0]  w_wr_ptr;
  logic [PW:0]    w_count;
  logic           w_empty;
  logic           w_almost_full;

  // Combine the downstream stalls and pack the incoming fetch payload.
  always_comb begin
    w_down_stall         = i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
    w_wr_entry.instr     = i_instruction;
    w_wr_entry.abort     = i_instr_abort;
    w_wr_entry.pc        = i_pc_ff;
    w_wr_entry.pc_plus_8 = i_pc_plus_8_ff;
    w_wr_entry.taken     = i_taken;
  end

  zap_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_down_stall           (w_down_stall),
    .i_clear_from_decode    (i_clear_from_decode),
    .i_push_req             (i_valid),
    .o_push                 (w_push),
    .o_pop                  (w_pop),
    .o_rd_ptr               (w_rd_ptr),
    .o_wr_ptr               (w_wr_ptr),
    .o_count                (w_count),
    .o_empty                (w_empty),
    .o_almost_full          (w_almost_full)
  );

  // Flop-array storage; contents need no reset since the empty state masks them.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= w_wr_entry;
    end
  end

  // Head read is asynchronous from storage; empty forces the idle entry.
  always_comb begin
    w_head = w_empty ? fq_idle_entry() : r_mem[w_rd_ptr];
    o_instruction      = w_head.instr;
    o_instr_abort      = w_head.abort;
    o_pc_ff            = w_head.pc;
    o_pc_plus_8_ff     = w_head.pc_plus_8;
    o_taken_ff         = w_head.taken;
    o_valid            = ~w_empty;
    o_stall_from_queue = w_almost_full;
  end

  // Pop and count are consumed inside the controller only.
  logic w_unused;
  always_comb begin
    w_unused = w_pop ^ (^w_count);
  end

endmodule

`default_nettype wire
